// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared definitions for the digit scanner. Holds the FSM
//                state encoding, default slot timing, slot count, nibble
//                width and a helper that picks one slot's nibble out of
//                the packed digit word.
//  Revision    : 1.0  initial release
// ============================================================================
package scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BLANK = 2'b01,
      ST_SHOW  = 2'b10
   } scan_state_e;

   localparam int DIV_DEFAULT   = 50000;
   localparam int BLANK_DEFAULT = 8;
   localparam int NUM_SLOTS     = 4;
   localparam int NIB_W         = 4;

   // Select the nibble that belongs to slot idx.
   function automatic logic [NIB_W-1:0] slot_nibble(
      input logic [NUM_SLOTS*NIB_W-1:0] d,
      input logic [1:0]                 idx
   );
      return d[idx*NIB_W +: NIB_W];
   endfunction

endpackage : scan_pkg
`default_nettype wire

// File: rtl/slot_timer.sv
`default_nettype none
// ============================================================================
//  Module      : slot_timer
//  Description : Per-slot cycle counter. Counts 0..DIV-1 and wraps, flags the
//                last blanking cycle and the last cycle of the slot.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                clear       - force the counter to 0 (scanner idle)
//                count       - current cycle within the slot
//                blank_done  - count is the last blanking cycle
//                slot_done   - count is the last cycle of the slot
//  Revision    : 1.0  initial release
// ============================================================================
module slot_timer #(
   parameter int DIV   = 50000,
   parameter int BLANK = 8,
   parameter int CW    = $clog2(DIV)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   output logic [CW-1:0] count,
   output logic          blank_done,
   output logic          slot_done
);

   localparam logic [CW-1:0] c_slot_last  = CW'(DIV - 1);
   localparam logic [CW-1:0] c_blank_last = CW'(BLANK - 1);

   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || (cnt_q == c_slot_last)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count      = cnt_q;
   assign blank_done = (cnt_q == c_blank_last);
   assign slot_done  = (cnt_q == c_slot_last);

endmodule : slot_timer
`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_ctrl
//  Description : Time-multiplexed four-slot digit scanner feeding a 2x4
//                one-hot decoder. Each slot is BLANK cycles dark followed by
//                DIV-BLANK cycles lit. The slot's nibble and decimal point are
//                captured at slot entry and held for the whole slot.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                run         - scanning enable, low forces idle
//                digits      - four nibbles, slot i in [4i+3:4i]
//                dp_mask     - decimal point per slot
//                sel_a/sel_b - slot index MSB/LSB to decoder A/B
//                sel_en      - decoder enable, high in the show phase only
//                nibble, dp  - value for the current slot
//                slot_tick   - pulse on the last lit cycle of each slot
//  Revision    : 1.0  initial release
// ============================================================================
module digit_scan_ctrl
   import scan_pkg::*;
#(
   parameter int DIV   = DIV_DEFAULT,
   parameter int BLANK = BLANK_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       run,
   input  logic [NUM_SLOTS*NIB_W-1:0] digits,
   input  logic [NUM_SLOTS-1:0]       dp_mask,
   output logic                       sel_a,
   output logic                       sel_b,
   output logic                       sel_en,
   output logic [NIB_W-1:0]           nibble,
   output logic                       dp,
   output logic                       slot_tick
);

   localparam int            CW         = $clog2(DIV);
   localparam logic [CW-1:0] c_pre_last = CW'(DIV - 2);

   scan_state_e      state_d, state_q;
   logic [1:0]       idx_d, idx_q;
   logic [NIB_W-1:0] nib_d, nib_q;
   logic             dp_d, dp_q;
   logic             sel_en_d, sel_en_q;
   logic             tick_d, tick_q;
   logic [1:0]       idx_nxt;

   logic [CW-1:0]    count;
   logic             blank_done;
   logic             slot_done;

   slot_timer #(
      .DIV   (DIV),
      .BLANK (BLANK),
      .CW    (CW)
   ) u_slot_timer (
      .clk        (clk),
      .rst        (rst),
      .clear      ((state_q == ST_IDLE) || !run),
      .count      (count),
      .blank_done (blank_done),
      .slot_done  (slot_done)
   );

   assign idx_nxt = idx_q + 2'd1;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      nib_d    = nib_q;
      dp_d     = dp_q;
      sel_en_d = 1'b0;
      tick_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_BLANK;
               idx_d   = 2'd0;
               nib_d   = slot_nibble(digits, 2'd0);
               dp_d    = dp_mask[0];
            end
         end
         ST_BLANK: begin
            if (blank_done) begin
               state_d  = ST_SHOW;
               sel_en_d = 1'b1;
            end
         end
         ST_SHOW: begin
            sel_en_d = 1'b1;
            // Outputs are registered, so raise the tick one cycle early to
            // land on the final lit cycle.
            tick_d   = (count == c_pre_last);
            if (slot_done) begin
               // Lamp goes dark on the same edge the index advances.
               state_d  = ST_BLANK;
               idx_d    = idx_nxt;
               nib_d    = slot_nibble(digits, idx_nxt);
               dp_d     = dp_mask[idx_nxt];
               sel_en_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Dropping run abandons the slot immediately, without a tick.
      if (!run) begin
         state_d  = ST_IDLE;
         idx_d    = 2'd0;
         nib_d    = '0;
         dp_d     = 1'b0;
         sel_en_d = 1'b0;
         tick_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= 2'd0;
         nib_q    <= '0;
         dp_q     <= 1'b0;
         sel_en_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         nib_q    <= nib_d;
         dp_q     <= dp_d;
         sel_en_q <= sel_en_d;
         tick_q   <= tick_d;
      end
   end

   assign sel_a     = idx_q[1];
   assign sel_b     = idx_q[0];
   assign sel_en    = sel_en_q;
   assign nibble    = nib_q;
   assign dp        = dp_q;
   assign slot_tick = tick_q;

endmodule : digit_scan_ctrl
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_scan_ctrl
//  Description : Directed self-checking bench for digit_scan_ctrl with
//                DIV=10, BLANK=2, including a behavioural 2x4 decoder
//                downstream of the select outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_digit_scan_ctrl;

   localparam int DIV   = 10;
   localparam int BLANK = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic        sel_a, sel_b, sel_en, dp, slot_tick;
   logic [3:0]  nibble;
   logic [3:0]  y;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   digit_scan_ctrl #(
      .DIV   (DIV),
      .BLANK (BLANK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .digits    (digits),
      .dp_mask   (dp_mask),
      .sel_a     (sel_a),
      .sel_b     (sel_b),
      .sel_en    (sel_en),
      .nibble    (nibble),
      .dp        (dp),
      .slot_tick (slot_tick)
   );

   // Downstream 2x4 one-hot decoder with enable.
   always_comb begin
      y = 4'b0000;
      if (sel_en) y[{sel_a, sel_b}] = 1'b1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Every output and the decoder must be quiet.
   task automatic chk_quiet(input string tag);
      chk({tag, " outs"}, int'({sel_a, sel_b, sel_en, nibble, dp, slot_tick}), 0);
      chk({tag, " y"}, int'(y), 0);
   endtask

   // Run n cycles from a fresh slot-0 entry, checking each cycle against the
   // hand-derived schedule: slot = t/10 mod 4, lit when t mod 10 >= 2,
   // tick when t mod 10 == 9. Slot 1 shows 2 before s1_t and 9 from s1_t on.
   // At t == chg_t digits[7:4] is changed to 9.
   task automatic run_cycles(input int n, input int s1_t, input int chg_t);
      int idx, ph, exp_nib, exp_y;
      for (int t = 0; t < n; t++) begin
         @(posedge clk);
         @(negedge clk);
         idx     = (t / DIV) % 4;
         ph      = t % DIV;
         exp_nib = (idx == 1) ? ((t >= s1_t) ? 9 : 2) : idx + 1;
         exp_y   = (ph >= BLANK) ? (1 << idx) : 0;
         chk($sformatf("sel t=%0d", t), int'({sel_a, sel_b}), idx);
         chk($sformatf("sel_en t=%0d", t), int'(sel_en), (ph >= BLANK) ? 1 : 0);
         chk($sformatf("nibble t=%0d", t), int'(nibble), exp_nib);
         chk($sformatf("dp t=%0d", t), int'(dp), (idx == 2) ? 1 : 0);
         chk($sformatf("tick t=%0d", t), int'(slot_tick), (ph == DIV - 1) ? 1 : 0);
         chk($sformatf("y t=%0d", t), int'(y), exp_y);
         if (t == chg_t) digits = 16'h4391;
      end
   endtask

   initial begin
      rst     = 1'b1;
      run     = 1'b1;
      digits  = 16'h4321;
      dp_mask = 4'b0100;

      // Reset held three cycles with run high.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk_quiet($sformatf("reset c%0d", i));
      end
      rst = 1'b0;

      // Full frames, mid-slot data change in slot 1 show phase, up to
      // counter 5 of slot 2 in the second frame.
      run_cycles(66, 40, 15);

      // Drop run: everything quiet from the next edge, no tick.
      run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk_quiet($sformatf("rundrop c%0d", i));
      end

      // Restart from slot 0 with a full blank; up to counter 5 of slot 3.
      run = 1'b1;
      run_cycles(36, 0, -1);

      // Reset during show of slot 3.
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_quiet("midrst");
      rst = 1'b0;

      // Resume from slot 0.
      run_cycles(12, 0, -1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_digit_scan_ctrl
`default_nettype wire

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexed digit scanner that drives the select inputs (A, B, en) of the 2x4 one-hot decoder and presents the matching 4-bit digit value to the segment path. It cycles through four digit slots. Each slot opens with a blanking interval so that digits do not ghost. The block sits directly upstream of the decoder: sel_a→A, sel_b→B, sel_en→en.

## Interface
- DIV, default 50000: clock cycles per digit slot (blank plus show); legal range ≥ BLANK+2.
- BLANK, default 8: blanked cycles at the start of each slot; legal range ≥ 1.
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  scanning enable; low forces idle.
- digits  in  16  four nibbles; digits[4i+3:4i] belongs to slot i.
- dp_mask  in  4  decimal point per slot; bit i belongs to slot i.
- sel_a  out  1  slot index MSB, to decoder A.
- sel_b  out  1  slot index LSB, to decoder B.
- sel_en  out  1  decoder enable; high only during the show phase.
- nibble  out  4  digit value for the current slot.
- dp  out  1  decimal point for the current slot.
- slot_tick  out  1  one-cycle pulse on the last cycle of every show phase.

## Operation
- States: IDLE, BLANK, SHOW.
- Reset value of every output is 0: sel_a=0, sel_b=0, sel_en=0, nibble=0, dp=0, slot_tick=0. State is IDLE, slot index is 0, cycle counter is 0.
- IDLE:
  - Outputs hold their reset values.
  - run=1 moves to BLANK with index 0 and counter 0.
- Slot entry (every transition into BLANK):
  - {sel_a, sel_b} takes the new index.
  - nibble and dp are latched from digits and dp_mask for that index.
  - Both values are then frozen for the entire slot; input changes mid-slot have no effect until the next slot entry.
- BLANK:
  - sel_en=0.
  - The counter counts 0..BLANK-1, then the state moves to SHOW.
- SHOW:
  - sel_en=1.
  - The counter continues to DIV-1.
  - On the cycle where the counter is DIV-1, slot_tick=1.
  - The next state is BLANK with index = (index+1) mod 4, so 3 wraps to 0, and the counter resets to 0.
- run=0 in BLANK or SHOW: the next state is IDLE and all outputs return to their reset values (index 0, sel_en=0). No slot is completed and no slot_tick is issued.
- rst wins over run in the same cycle.
- rst mid-slot produces reset values on the next edge, regardless of state.
- Counter width is $clog2(DIV). The counter never exceeds DIV-1.
- The index is 2 bits and wraps naturally.
- Exactly one decoder output is active whenever sel_en=1. There is no cycle in which sel changes while sel_en=1.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- If run is first sampled high at edge k:
  - At edge k+1: BLANK, sel=00, sel_en=0.
  - At edge k+1+BLANK: sel_en=1.
- Slot period is exactly DIV cycles: BLANK cycles with sel_en=0, then DIV-BLANK cycles with sel_en=1.
- Frame period is exactly 4·DIV cycles.
- slot_tick is high for one cycle, coincident with the last sel_en=1 cycle of the slot.
- sel_en falls on the same edge that sel advances.
- If run drops at edge m, sel_en=0 from edge m+1.

## Structure
- Shared package scan_pkg holds:
  - the state encoding (IDLE=2'b00, BLANK=2'b01, SHOW=2'b10);
  - the default DIV and BLANK constants;
  - the slot count (4) and nibble width (4).
- Natural sub-module: slot_timer.
  - Parameterised by DIV and BLANK.
  - Holds the cycle counter.
  - Emits blank_done, slot_done, and the count.
  - Cleared by rst or by a clear input asserted on IDLE.
- The FSM, the index register and the output latches live in digit_scan_ctrl.

## Test plan
All scenarios use DIV=10, BLANK=2.
- Reset: rst=1 for 3 cycles with run=1 → all outputs 0 and state IDLE. After rst falls, sel_en first goes high exactly 3 edges later (BLANK, then SHOW).
- Full frame: run=1, digits=16'h4321, dp_mask=4'b0100 →
  - nibble sequence 1,2,3,4 and then back to 1;
  - dp=1 only in slot 2;
  - sel_en high for 8 of every 10 cycles;
  - slot_tick every 10 cycles;
  - sel wraps from 11 to 00.
- Mid-slot data change: in SHOW of slot 1, change digits[7:4] from 2 to 9 → nibble stays 2 for the rest of slot 1 and reads 9 in slot 1 of the next frame.
- run drop: deassert run at counter 5 of slot 2 → next edge gives sel_en=0, sel=00, nibble=0, and no slot_tick. Reasserting run restarts at slot 0 with a full BLANK phase.
- Reset mid-operation: assert rst during SHOW of slot 3 → next edge gives all outputs 0. After release and with run=1, the scan resumes from slot 0.
- Decoder pairing with the decoder instantiated downstream: check that Y is one-hot equal to 1<<sel whenever sel_en=1 and that Y=0 throughout BLANK and IDLE.
